// File: rtl/intersection_scheduler.sv
// Timed two-road intersection sequencer with a serviced pedestrian walk phase.
// Phase timing comes from a saturating per-phase counter. Lamp outputs are registered decodes of the next state.
module intersection_scheduler #(
  parameter int CNT_W    = 8,
  parameter int MIN_GRN  = 10,
  parameter int MAX_GRN  = 60,
  parameter int YEL_CYC  = 5,
  parameter int RED_CYC  = 2,
  parameter int WALK_CYC = 20
) (
  input  logic       clk,
  input  logic       r,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_GA   = 3'd0,
    S_YA   = 3'd1,
    S_RA   = 3'd2,
    S_GB   = 3'd3,
    S_YB   = 3'd4,
    S_RB   = 3'd5,
    S_WALK = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;

  // Counter values on the final cycle of each phase.
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYC - 1);

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] cnt;
  logic             side;   // 0: road A served next after walk, 1: road B
  logic             change;

  always_comb begin
    next = state;
    unique case (state)
      S_GA:   if ((cnt >= MIN_LAST && (!ta || ped_pend)) || cnt == MAX_LAST) next = S_YA;
      S_YA:   if (cnt == YEL_LAST) next = S_RA;
      S_RA:   if (cnt == RED_LAST) next = ped_pend ? S_WALK : S_GB;
      S_GB:   if ((cnt >= MIN_LAST && (!tb || ped_pend)) || cnt == MAX_LAST) next = S_YB;
      S_YB:   if (cnt == YEL_LAST) next = S_RB;
      S_RB:   if (cnt == RED_LAST) next = ped_pend ? S_WALK : S_GA;
      S_WALK: if (cnt == WALK_LAST) next = side ? S_GB : S_GA;
      default: next = S_GA;
    endcase
    change = (next != state);
  end

  function automatic logic [1:0] lamp_a(input state_t s);
    case (s)
      S_GA:    lamp_a = LAMP_GRN;
      S_YA:    lamp_a = LAMP_YEL;
      default: lamp_a = LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input state_t s);
    case (s)
      S_GB:    lamp_b = LAMP_GRN;
      S_YB:    lamp_b = LAMP_YEL;
      default: lamp_b = LAMP_RED;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (r) begin
      state    <= S_GA;
      cnt      <= '0;
      side     <= 1'b0;
      ped_pend <= 1'b0;
      la       <= LAMP_GRN;
      lb       <= LAMP_RED;
      walk     <= 1'b0;
      phase    <= S_GA;
    end else begin
      state <= next;
      if (change)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;

      if (state == S_RA && change) side <= 1'b1;
      if (state == S_RB && change) side <= 1'b0;

      // Entering walk services the request; a press on that same edge is dropped.
      if (next == S_WALK && state != S_WALK)
        ped_pend <= 1'b0;
      else if (state != S_WALK && ped)
        ped_pend <= 1'b1;

      la    <= lamp_a(next);
      lb    <= lamp_b(next);
      walk  <= (next == S_WALK);
      phase <= next;
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboarded bench for intersection_scheduler: a phase/age reference model predicts
// {phase, la, lb, walk, ped_pend} after every edge and a monitor compares.
module tb_intersection_scheduler;

  localparam int MIN_GRN  = 10;
  localparam int MAX_GRN  = 60;
  localparam int YEL_CYC  = 5;
  localparam int RED_CYC  = 2;
  localparam int WALK_CYC = 20;

  logic       clk = 1'b0;
  logic       r = 1'b1, ta = 1'b0, tb = 1'b0, ped = 1'b0;
  logic [1:0] la, lb;
  logic       walk, ped_pend;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];

  intersection_scheduler #(
    .CNT_W(8), .MIN_GRN(MIN_GRN), .MAX_GRN(MAX_GRN),
    .YEL_CYC(YEL_CYC), .RED_CYC(RED_CYC), .WALK_CYC(WALK_CYC)
  ) dut (
    .clk(clk), .r(r), .ta(ta), .tb(tb), .ped(ped),
    .la(la), .lb(lb), .walk(walk), .ped_pend(ped_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..6, cycles already spent in it, pending request, side.
  int m_phase = 0;
  int m_age   = 0;
  bit m_pend  = 0;
  bit m_side  = 0;
  int lamp_a_tab[7] = '{0, 1, 2, 2, 2, 2, 2};
  int lamp_b_tab[7] = '{2, 2, 2, 0, 1, 2, 2};
  int dur_tab[7]    = '{0, YEL_CYC, RED_CYC, 0, YEL_CYC, RED_CYC, WALK_CYC};

  task automatic model_step(input bit rr, input bit a, input bit b, input bit p);
    int  served;
    int  nxt;
    bit  demand;
    if (rr) begin
      m_phase = 0; m_age = 0; m_pend = 0; m_side = 0;
      return;
    end
    served = m_age + 1;
    nxt = m_phase;
    if (m_phase == 0 || m_phase == 3) begin
      demand = (m_phase == 0) ? a : b;
      if ((served >= MIN_GRN && (!demand || m_pend)) || served == MAX_GRN)
        nxt = m_phase + 1;
    end else if (served == dur_tab[m_phase]) begin
      case (m_phase)
        1, 4: nxt = m_phase + 1;
        2:    begin nxt = m_pend ? 6 : 3; m_side = 1; end
        5:    begin nxt = m_pend ? 6 : 0; m_side = 0; end
        default: nxt = m_side ? 3 : 0;
      endcase
    end
    if (nxt == 6 && m_phase != 6) m_pend = 0;
    else if (m_phase != 6 && p)   m_pend = 1;
    m_age   = (nxt != m_phase) ? 0 : served;
    m_phase = nxt;
  endtask

  function automatic logic [8:0] model_out();
    logic [2:0] ph = 3'(m_phase);
    logic [1:0] a  = 2'(lamp_a_tab[m_phase]);
    logic [1:0] b  = 2'(lamp_b_tab[m_phase]);
    return {ph, a, b, (m_phase == 6), m_pend};
  endfunction

  task automatic step(input bit rr, input bit a, input bit b, input bit p);
    @(negedge clk);
    r = rr; ta = a; tb = b; ped = p;
    model_step(rr, a, b, p);
    exp_q.push_back(model_out());
  endtask

  // Monitor: outputs are valid every cycle once stimulus has begun.
  initial begin
    logic [8:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {phase, la, lb, walk, ped_pend};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got phase=%0d la=%b lb=%b walk=%b pend=%b, expected phase=%0d la=%b lb=%b walk=%b pend=%b",
                   $time, got[8:6], got[5:4], got[3:2], got[1], got[0],
                   e[8:6], e[5:4], e[3:2], e[1], e[0]);
        end
        if (walk === 1'b1 && (la !== 2'b10 || lb !== 2'b10)) begin
          fails++;
          $display("FAIL walk_safety @%0t: walk=1 with la=%b lb=%b, required both 10", $time, la, lb);
        end
        if (la !== 2'b10 && lb !== 2'b10) begin
          fails++;
          $display("FAIL road_conflict @%0t: la=%b lb=%b, required one road red", $time, la, lb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta_hold, tb_hold;
    bit a_v, b_v;
    // Idle cycle with no traffic: 10/5/2/10/5/2 and back to GA.
    repeat (2) step(1, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0);
    // Road A demand held: max green.
    step(1, 0, 0, 0);
    repeat (75) step(0, 1, 0, 0);
    // Pedestrian pulse during held A green.
    step(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, (i == 3));
    // Road B demand held into its green, then dropped.
    step(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, (i < 40), 0);
    // Reset asserted partway through YB.
    step(1, 0, 0, 0);
    repeat (29) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    // Pedestrian button held continuously.
    repeat (200) step(0, 1, 1, 1);
    // Randomised traffic, pedestrian presses and occasional reset.
    ta_hold = 0; tb_hold = 0; a_v = 0; b_v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ta_hold == 0) begin a_v = 1'($urandom_range(0, 1)); ta_hold = $urandom_range(1, 80); end
      if (tb_hold == 0) begin b_v = 1'($urandom_range(0, 1)); tb_hold = $urandom_range(1, 80); end
      ta_hold--; tb_hold--;
      step(($urandom_range(0, 499) == 0), a_v, b_v, ($urandom_range(0, 39) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
